// File: rtl/keypad_display_rx.sv
// Keypad entry register with 4-digit multiplexed seven-segment display, sticky error flag and
// key-accept beeper. Digits shift in from the right; long-press clears the entry.
module keypad_display_rx #(
  parameter int unsigned SCAN_BITS   = 17,
  parameter int unsigned BEEP_CYCLES = 8192
) (
  input  logic       f4m,
  input  logic       rst_n,
  input  logic [3:0] key_code,
  input  logic       key_strb,
  input  logic       key_hold,
  output logic [6:0] seg_n,
  output logic [3:0] dig_n,
  output logic [2:0] cnt,
  output logic       err,
  output logic       beep
);

  localparam int unsigned BeepW = $clog2(BEEP_CYCLES + 1);

  logic [3:0][3:0]      digs_q, digs_d;
  logic [2:0]           cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic [BeepW-1:0]     beep_cnt_q, beep_cnt_d;
  logic [SCAN_BITS-1:0] scan_q;
  logic                 accept;
  logic [1:0]           phase;
  logic [3:0]           cur;
  logic                 blank;

  always_ff @(posedge f4m or negedge rst_n) begin
    if (!rst_n) begin
      digs_q     <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      beep_cnt_q <= '0;
      scan_q     <= '0;
    end else begin
      digs_q     <= digs_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      beep_cnt_q <= beep_cnt_d;
      scan_q     <= scan_q + SCAN_BITS'(1);
    end
  end

  // Long-press has priority over any strobe in the same cycle.
  assign accept = key_strb && !key_hold && (key_code <= 4'd9);

  always_comb begin
    digs_d     = digs_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    beep_cnt_d = beep_cnt_q;
    if (key_hold) begin
      digs_d = '0;
      cnt_d  = '0;
      err_d  = 1'b0;
    end else if (key_strb) begin
      if (accept) begin
        digs_d = {digs_q[2:0], key_code};
        if (cnt_q < 3'd4) cnt_d = cnt_q + 3'd1;
      end else begin
        err_d = 1'b1;
      end
    end
    if (accept) begin
      beep_cnt_d = BeepW'(BEEP_CYCLES);
    end else if (beep_cnt_q != '0) begin
      beep_cnt_d = beep_cnt_q - BeepW'(1);
    end
  end

  assign phase = scan_q[SCAN_BITS-1 -: 2];

  always_comb begin
    dig_n = 4'b1110;
    cur   = digs_q[0];
    unique case (phase)
      2'd0: begin dig_n = 4'b1110; cur = digs_q[0]; end
      2'd1: begin dig_n = 4'b1101; cur = digs_q[1]; end
      2'd2: begin dig_n = 4'b1011; cur = digs_q[2]; end
      2'd3: begin dig_n = 4'b0111; cur = digs_q[3]; end
      default: begin dig_n = 4'b1110; cur = digs_q[0]; end
    endcase
  end

  // Leading-zero blanking: positions at or beyond the entered count stay dark, d0 always lit.
  assign blank = (phase != 2'd0) && ({1'b0, phase} >= cnt_q);

  always_comb begin
    seg_n = 7'b1111111;
    if (!blank) begin
      unique case (cur)
        4'd0:    seg_n = 7'b1000000;
        4'd1:    seg_n = 7'b1111001;
        4'd2:    seg_n = 7'b0100100;
        4'd3:    seg_n = 7'b0110000;
        4'd4:    seg_n = 7'b0011001;
        4'd5:    seg_n = 7'b0010010;
        4'd6:    seg_n = 7'b0000010;
        4'd7:    seg_n = 7'b1111000;
        4'd8:    seg_n = 7'b0000000;
        4'd9:    seg_n = 7'b0010000;
        default: seg_n = 7'b1111111;
      endcase
    end
  end

  assign cnt  = cnt_q;
  assign err  = err_q;
  assign beep = (beep_cnt_q != '0);

endmodule

// File: tb/tb_keypad_display_rx.sv
// Directed bench for keypad_display_rx: entry, blanking, error, clear, beep timing and async reset.
module tb_keypad_display_rx;

  localparam int unsigned ScanBits  = 6;
  localparam int unsigned BeepCyc   = 8192;

  logic       f4m = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] key_code = 4'd0;
  logic       key_strb = 1'b0;
  logic       key_hold = 1'b0;
  logic [6:0] seg_n;
  logic [3:0] dig_n;
  logic [2:0] cnt;
  logic       err;
  logic       beep;

  int checks = 0;
  int errors = 0;

  keypad_display_rx #(
    .SCAN_BITS  (ScanBits),
    .BEEP_CYCLES(BeepCyc)
  ) dut (
    .f4m     (f4m),
    .rst_n   (rst_n),
    .key_code(key_code),
    .key_strb(key_strb),
    .key_hold(key_hold),
    .seg_n   (seg_n),
    .dig_n   (dig_n),
    .cnt     (cnt),
    .err     (err),
    .beep    (beep)
  );

  always #5 f4m = ~f4m;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge f4m);
    #1;
  endtask

  task automatic press(input logic [3:0] code);
    key_code = code;
    key_strb = 1'b1;
    tick();
    key_strb = 1'b0;
  endtask

  task automatic wait_phase(input int k);
    logic [3:0] want;
    int n;
    want = ~(4'b0001 << k);
    n = 0;
    while (dig_n !== want && n < 80) begin
      tick();
      n++;
    end
    if (dig_n !== want) begin
      errors++;
      $display("FAIL wait_phase%0d: dig_n %b never reached %b", k, dig_n, want);
    end
  endtask

  initial begin
    int hi;
    int n;

    #1 rst_n = 1'b0;
    #3;
    check("rst_dig", dig_n, 4'b1110);
    check("rst_seg", seg_n, 7'b1000000);
    check("rst_cnt", cnt, 0);
    check("rst_err", err, 0);
    check("rst_beep", beep, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // Scan counter: 15 edges stay in phase 0, the 16th enters phase 1.
    repeat (15) tick();
    check("scan_ph0", dig_n, 4'b1110);
    tick();
    check("scan_ph1", dig_n, 4'b1101);

    // Three digits entered.
    press(4'd1);
    press(4'd2);
    press(4'd3);
    check("cnt3", cnt, 3);
    check("beep_on", beep, 1);
    wait_phase(3); check("p3_blank", seg_n, 7'b1111111);
    wait_phase(0); check("p0_3", seg_n, 7'b0110000);
    wait_phase(1); check("p1_2", seg_n, 7'b0100100);
    wait_phase(2); check("p2_1", seg_n, 7'b1111001);

    // Saturation: d3..d0 = 2,3,4,5.
    press(4'd4);
    press(4'd5);
    check("cnt4", cnt, 4);
    wait_phase(3); check("p3_2", seg_n, 7'b0100100);
    wait_phase(0); check("p0_5", seg_n, 7'b0010010);
    wait_phase(1); check("p1_4", seg_n, 7'b0011001);
    wait_phase(2); check("p2_3", seg_n, 7'b0110000);

    // Invalid code.
    press(4'd12);
    check("err_set", err, 1);
    check("err_cnt", cnt, 4);
    check("err_beep", beep, 1);
    wait_phase(0); check("err_p0", seg_n, 7'b0010010);

    // Long-press clears.
    key_hold = 1'b1;
    tick();
    key_hold = 1'b0;
    check("hold_err", err, 0);
    check("hold_cnt", cnt, 0);
    wait_phase(0); check("hold_p0", seg_n, 7'b1000000);
    wait_phase(1); check("hold_p1", seg_n, 7'b1111111);

    // Let the beep expire before timing a fresh one.
    n = 0;
    while (beep !== 1'b0 && n < 9000) begin
      tick();
      n++;
    end
    check("beep_idle", beep, 0);

    // Second key 100 cycles after the first: 100 + 8192 continuous high cycles.
    press(4'd1);
    hi = (beep === 1'b1) ? 1 : 0;
    repeat (99) begin
      tick();
      if (beep === 1'b1) hi++;
    end
    press(4'd2);
    if (beep === 1'b1) hi++;
    n = 0;
    while (beep === 1'b1 && n < 9000) begin
      tick();
      n++;
      if (beep === 1'b1) hi++;
    end
    check("beep_len", hi, 100 + BeepCyc);
    check("beep_off", beep, 0);
    check("two_cnt", cnt, 2);

    // Hold wins over a simultaneous strobe; no beep.
    key_code = 4'd7;
    key_strb = 1'b1;
    key_hold = 1'b1;
    tick();
    key_strb = 1'b0;
    key_hold = 1'b0;
    check("sim_cnt", cnt, 0);
    check("sim_beep", beep, 0);
    hi = 0;
    repeat (10) begin
      tick();
      if (beep === 1'b1) hi++;
    end
    check("sim_nobeep", hi, 0);
    wait_phase(0); check("sim_p0", seg_n, 7'b1000000);

    // Two-cycle strobe registers two keys.
    key_code = 4'd9;
    key_strb = 1'b1;
    tick();
    tick();
    key_strb = 1'b0;
    check("multi_cnt", cnt, 2);
    wait_phase(1); check("multi_p1", seg_n, 7'b0010000);

    // Async reset mid-beep during phase 2.
    wait_phase(2);
    check("pre_rst_beep", beep, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_beep", beep, 0);
    check("arst_dig", dig_n, 4'b1110);
    check("arst_seg", seg_n, 7'b1000000);
    check("arst_cnt", cnt, 0);
    #3 rst_n = 1'b1;
    tick();
    check("post_rst_dig", dig_n, 4'b1110);
    check("post_rst_beep", beep, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
